// File: rtl/legv8_multicycle_sequencer.sv
// Multicycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT with registered control outputs.
// Optional macro FLAG_SET_EN enables ADDS/SUBS decode and the status-load strobe SL.
module legv8_multicycle_sequencer #(
    parameter int unsigned MEM_WAIT = 32'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    output logic [24:0] control_word,
    output logic [63:0] K,
    output logic [1:0]  PS,
    output logic        SL,
    output logic        IR_load,
    output logic [2:0]  state,
    output logic        halt
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_HALT   = 3'b111
    } state_t;

    typedef enum logic [2:0] {
        IC_R   = 3'd0,
        IC_I   = 3'd1,
        IC_LD  = 3'd2,
        IC_ST  = 3'd3,
        IC_CBZ = 3'd4,
        IC_B   = 3'd5,
        IC_BAD = 3'd6
    } iclass_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01011;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    // Writes to X31 are discarded here so no opcode path can clobber the zero register.
    function automatic logic [24:0] pack_cw(
        input logic [4:0] sa,
        input logic [4:0] sb,
        input logic [4:0] da,
        input logic       rw,
        input logic       mw,
        input logic [4:0] fs,
        input logic       bsel,
        input logic       en_mem,
        input logic       en_alu
    );
        return {sa, sb, da, rw & (da != 5'd31), mw, fs, bsel, en_mem, en_alu};
    endfunction

    state_t      state_r, state_nxt_s;
    logic [31:0] ir_r;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic [24:0] cw_r, cw_nxt_s;
    logic [63:0] k_r, k_nxt_s;
    logic [1:0]  ps_r, ps_nxt_s;
    logic        sl_r, sl_nxt_s;
    logic        irl_r, irl_nxt_s;
    logic        halt_r, halt_nxt_s;
    logic        cbz_r, cbz_nxt_s;
    logic [31:0] cur_instr_s;
    iclass_t     iclass_s;
    logic [4:0]  fs_s;
    logic        flag_op_s;
    logic        mem_last_s;
    logic [63:0] k_imm12_s, k_d_s, k_cb_s, k_b_s;
    logic        unused_status_s;

    // In DECODE the ROM word is used directly; afterwards the latched copy drives decode.
    assign cur_instr_s = (state_r == ST_DECODE) ? instruction : ir_r;
    assign k_imm12_s   = {52'd0, cur_instr_s[21:10]};
    assign k_d_s       = {{55{cur_instr_s[20]}}, cur_instr_s[20:12]};
    assign k_cb_s      = {{45{cur_instr_s[23]}}, cur_instr_s[23:5]};
    assign k_b_s       = {{38{cur_instr_s[25]}}, cur_instr_s[25:0]};
    assign mem_last_s  = (cnt_nxt_s == WAIT_LAST);
    assign unused_status_s = ^status[4:1];

    // Opcode classification and ALU function select.
    always_comb begin
        iclass_s  = IC_BAD;
        fs_s      = FS_ADD;
        flag_op_s = 1'b0;
        if (cur_instr_s[31:21] == 11'b10001011000) begin
            iclass_s = IC_R;
            fs_s     = FS_ADD;
        end else if (cur_instr_s[31:21] == 11'b11001011000) begin
            iclass_s = IC_R;
            fs_s     = FS_SUB;
        end else if (cur_instr_s[31:21] == 11'b10001010000) begin
            iclass_s = IC_R;
            fs_s     = FS_AND;
        end else if (cur_instr_s[31:21] == 11'b10101010000) begin
            iclass_s = IC_R;
            fs_s     = FS_ORR;
`ifdef FLAG_SET_EN
        end else if (cur_instr_s[31:21] == 11'b10101011000) begin
            iclass_s  = IC_R;
            fs_s      = FS_ADD;
            flag_op_s = 1'b1;
        end else if (cur_instr_s[31:21] == 11'b11101011000) begin
            iclass_s  = IC_R;
            fs_s      = FS_SUB;
            flag_op_s = 1'b1;
`endif
        end else if (cur_instr_s[31:22] == 10'b1001000100) begin
            iclass_s = IC_I;
            fs_s     = FS_ADD;
        end else if (cur_instr_s[31:22] == 10'b1101000100) begin
            iclass_s = IC_I;
            fs_s     = FS_SUB;
        end else if (cur_instr_s[31:21] == 11'b11111000010) begin
            iclass_s = IC_LD;
        end else if (cur_instr_s[31:21] == 11'b11111000000) begin
            iclass_s = IC_ST;
        end else if (cur_instr_s[31:24] == 8'b10110100) begin
            iclass_s = IC_CBZ;
        end else if (cur_instr_s[31:26] == 6'b000101) begin
            iclass_s = IC_B;
        end else begin
            iclass_s = IC_BAD;
        end
    end

    // Next-state and memory wait counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_FETCH:  state_nxt_s = ST_DECODE;
            ST_DECODE: state_nxt_s = (iclass_s == IC_BAD) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if ((iclass_s == IC_LD) || (iclass_s == IC_ST)) begin
                    state_nxt_s = ST_MEM;
                    cnt_nxt_s   = 4'd1;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (cnt_r >= WAIT_LAST) begin
                    state_nxt_s = (iclass_s == IC_LD) ? ST_WB : ST_FETCH;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 4'd1;
                end
            end
            ST_WB:     state_nxt_s = ST_FETCH;
            ST_HALT:   state_nxt_s = ST_HALT;
            default:   state_nxt_s = ST_FETCH;
        endcase
    end

    // Outputs for the state being entered; they are registered on the same edge as the state.
    always_comb begin
        cw_nxt_s   = 25'd0;
        k_nxt_s    = 64'd0;
        ps_nxt_s   = 2'b00;
        sl_nxt_s   = 1'b0;
        irl_nxt_s  = 1'b0;
        halt_nxt_s = 1'b0;
        cbz_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_FETCH:  irl_nxt_s = 1'b1;
            ST_DECODE: irl_nxt_s = 1'b0;
            ST_EXEC: begin
                case (iclass_s)
                    IC_R: begin
                        cw_nxt_s = pack_cw(cur_instr_s[9:5], cur_instr_s[20:16], cur_instr_s[4:0],
                                           1'b1, 1'b0, fs_s, 1'b0, 1'b0, 1'b1);
                        ps_nxt_s = 2'b01;
                        sl_nxt_s = flag_op_s;
                    end
                    IC_I: begin
                        cw_nxt_s = pack_cw(cur_instr_s[9:5], cur_instr_s[20:16], cur_instr_s[4:0],
                                           1'b1, 1'b0, fs_s, 1'b1, 1'b0, 1'b1);
                        k_nxt_s  = k_imm12_s;
                        ps_nxt_s = 2'b01;
                    end
                    IC_LD, IC_ST: begin
                        cw_nxt_s = pack_cw(cur_instr_s[9:5], 5'd0, 5'd0,
                                           1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b1);
                        k_nxt_s  = k_d_s;
                    end
                    IC_CBZ: begin
                        cw_nxt_s  = pack_cw(5'd31, cur_instr_s[4:0], 5'd0,
                                            1'b0, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1);
                        k_nxt_s   = k_cb_s;
                        ps_nxt_s  = 2'b01;
                        cbz_nxt_s = 1'b1;
                    end
                    IC_B: begin
                        k_nxt_s  = k_b_s;
                        ps_nxt_s = 2'b10;
                    end
                    default: cw_nxt_s = 25'd0;
                endcase
            end
            ST_MEM: begin
                k_nxt_s = k_d_s;
                if (mem_last_s && (iclass_s == IC_ST)) begin
                    cw_nxt_s = pack_cw(cur_instr_s[9:5], cur_instr_s[4:0], 5'd0,
                                       1'b0, 1'b1, FS_ADD, 1'b1, 1'b0, 1'b1);
                    ps_nxt_s = 2'b01;
                end else begin
                    cw_nxt_s = pack_cw(cur_instr_s[9:5], 5'd0, 5'd0,
                                       1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b1);
                end
            end
            ST_WB: begin
                cw_nxt_s = pack_cw(cur_instr_s[9:5], 5'd0, cur_instr_s[4:0],
                                   1'b1, 1'b0, FS_ADD, 1'b1, 1'b1, 1'b0);
                k_nxt_s  = k_d_s;
                ps_nxt_s = 2'b01;
            end
            ST_HALT:   halt_nxt_s = 1'b1;
            default:   irl_nxt_s = 1'b0;
        endcase
    end

    // State, instruction latch, counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FETCH;
            ir_r    <= 32'd0;
            cnt_r   <= 4'd0;
            cw_r    <= 25'd0;
            k_r     <= 64'd0;
            ps_r    <= 2'b00;
            sl_r    <= 1'b0;
            irl_r   <= 1'b0;
            halt_r  <= 1'b0;
            cbz_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ir_r    <= (state_r == ST_DECODE) ? instruction : ir_r;
            cnt_r   <= cnt_nxt_s;
            cw_r    <= cw_nxt_s;
            k_r     <= k_nxt_s;
            ps_r    <= ps_nxt_s;
            sl_r    <= sl_nxt_s;
            irl_r   <= irl_nxt_s;
            halt_r  <= halt_nxt_s;
            cbz_r   <= cbz_nxt_s;
        end
    end

    // CBZ resolves against the live zero flag produced during its own EXEC cycle.
    assign PS           = cbz_r ? (status[0] ? 2'b10 : 2'b01) : ps_r;
    assign control_word = cw_r;
    assign K            = k_r;
    assign SL           = sl_r;
    assign IR_load      = irl_r;
    assign state        = state_r;
    assign halt         = halt_r;

endmodule

// File: tb/tb_legv8_multicycle_sequencer.sv
// Randomized self-checking bench: a per-instruction cycle-by-cycle expectation list is built from mnemonics.
module tb_legv8_multicycle_sequencer;

    localparam int MW = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [4:0]  status = 5'd0;
    logic [24:0] control_word;
    logic [63:0] K;
    logic [1:0]  PS;
    logic        SL, IR_load, halt;
    logic [2:0]  state;

    legv8_multicycle_sequencer #(.MEM_WAIT(MW)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .status(status),
        .control_word(control_word), .K(K), .PS(PS), .SL(SL), .IR_load(IR_load),
        .state(state), .halt(halt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  st;
        logic [24:0] cw;
        logic [63:0] k;
        logic [1:0]  ps;
        logic [2:0]  flags;  // {SL, IR_load, halt}
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   first_g  = 1'b1;
    bit   mw_watch = 1'b0;
    bit   mw_seen  = 1'b0;
`ifdef FLAG_SET_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    always @(control_word) if (mw_watch && control_word[8]) mw_seen = 1'b1;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [24:0] cw_of(input int sa, input int sb, input int da, input bit we,
                                          input bit mw, input logic [4:0] fs, input bit bsel,
                                          input bit enm, input bit ena);
        return {5'(sa), 5'(sb), 5'(da), we && (da != 31), mw, fs, bsel, enm, ena};
    endfunction

    function automatic rec_t mk(input int st, input logic [24:0] cw, input logic [63:0] k,
                                input int ps, input bit sl, input bit irl, input bit h);
        rec_t r;
        r.st = 3'(st); r.cw = cw; r.k = k; r.ps = 2'(ps); r.flags = {sl, irl, h};
        return r;
    endfunction

    function automatic string mnem(input logic [31:0] w);
        if (w[31:21] == 11'b10001011000) return "ADD";
        if (w[31:21] == 11'b11001011000) return "SUB";
        if (w[31:21] == 11'b10001010000) return "AND";
        if (w[31:21] == 11'b10101010000) return "ORR";
        if (w[31:21] == 11'b10101011000) return "ADDS";
        if (w[31:21] == 11'b11101011000) return "SUBS";
        if (w[31:21] == 11'b11111000010) return "LDUR";
        if (w[31:21] == 11'b11111000000) return "STUR";
        if (w[31:22] == 10'b1001000100)  return "ADDI";
        if (w[31:22] == 10'b1101000100)  return "SUBI";
        if (w[31:24] == 8'b10110100)     return "CBZ";
        if (w[31:26] == 6'b000101)       return "B";
        return "ILL";
    endfunction

    function automatic logic [4:0] alu_fs(input string m);
        if (m == "AND") return 5'b00000;
        if (m == "ORR") return 5'b00100;
        if (m == "SUB" || m == "SUBS" || m == "SUBI") return 5'b01011;
        return 5'b01000;
    endfunction

    // Expected per-cycle observation list for one instruction, FETCH onwards.
    function automatic void build(input logic [31:0] w, input bit first, input bit z);
        string       m   = mnem(w);
        int          rd  = int'(w[4:0]);
        int          rn  = int'(w[9:5]);
        int          rm  = int'(w[20:16]);
        logic [63:0] i12 = 64'(w[21:10]);
        logic [63:0] d9  = 64'($signed(w[20:12]));
        logic [63:0] cb  = 64'($signed(w[23:5]));
        logic [63:0] b26 = 64'($signed(w[25:0]));
        logic [24:0] addr = cw_of(rn, 0, 0, 0, 0, 5'b01000, 1, 0, 1);
        bit          fl   = (m == "ADDS" || m == "SUBS");
        exp_q.delete();
        exp_q.push_back(mk(0, 25'd0, 64'd0, 0, 0, !first, 0));
        exp_q.push_back(mk(1, 25'd0, 64'd0, 0, 0, 0, 0));
        if (m == "ILL" || (fl && !FLAGS_ON)) begin
            for (int i = 0; i < 20; i++) exp_q.push_back(mk(7, 25'd0, 64'd0, 0, 0, 0, 1));
        end else if (m == "ADD" || m == "SUB" || m == "AND" || m == "ORR" || fl) begin
            exp_q.push_back(mk(2, cw_of(rn, rm, rd, 1, 0, alu_fs(m), 0, 0, 1), 64'd0, 1, fl, 0, 0));
        end else if (m == "ADDI" || m == "SUBI") begin
            exp_q.push_back(mk(2, cw_of(rn, rm, rd, 1, 0, alu_fs(m), 1, 0, 1), i12, 1, 0, 0, 0));
        end else if (m == "LDUR" || m == "STUR") begin
            exp_q.push_back(mk(2, addr, d9, 0, 0, 0, 0));
            for (int i = 0; i < MW; i++) begin
                if (m == "STUR" && i == MW - 1)
                    exp_q.push_back(mk(3, cw_of(rn, rd, 0, 0, 1, 5'b01000, 1, 0, 1), d9, 1, 0, 0, 0));
                else
                    exp_q.push_back(mk(3, addr, d9, 0, 0, 0, 0));
            end
            if (m == "LDUR")
                exp_q.push_back(mk(4, cw_of(rn, 0, rd, 1, 0, 5'b01000, 1, 1, 0), d9, 1, 0, 0, 0));
        end else if (m == "CBZ") begin
            exp_q.push_back(mk(2, cw_of(31, rd, 0, 0, 0, 5'b01000, 0, 0, 1), cb, z ? 2 : 1, 0, 0, 0));
        end else begin
            exp_q.push_back(mk(2, 25'd0, b26, 2, 0, 0, 0));
        end
    endfunction

    task automatic compare(input rec_t r, input string tag);
        check_value({tag, "/state"}, 64'(state), 64'(r.st));
        check_value({tag, "/cw"}, 64'(control_word), 64'(r.cw));
        check_value({tag, "/K"}, K, r.k);
        check_value({tag, "/PS"}, 64'(PS), 64'(r.ps));
        check_value({tag, "/SL_IRL_halt"}, 64'({SL, IR_load, halt}), 64'(r.flags));
    endtask

    // Called just after a negedge; reset is asserted here and released on the next negedge.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        check_value("rst/state", 64'(state), 64'd0);
        check_value("rst/cw", 64'(control_word), 64'd0);
        check_value("rst/K", K, 64'd0);
        check_value("rst/PS", 64'(PS), 64'd0);
        check_value("rst/SL_IRL_halt", 64'({SL, IR_load, halt}), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        first_g = 1'b1;
    endtask

    // Runs one instruction starting mid-FETCH; stop_after>0 leaves it in flight after that many cycles.
    task automatic run_instr(input logic [31:0] w, input int zsel, input int stop_after);
        bit z = (zsel < 0) ? bit'($urandom_range(0, 1)) : bit'(zsel);
        int n;
        bit halted;
        instruction = w;
        status = {4'($urandom), z};
        build(w, first_g, z);
        halted = (exp_q[exp_q.size() - 1].st == 3'b111);
        n = (stop_after > 0) ? stop_after : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            compare(exp_q[i], $sformatf("%s_%08h_c%0d", mnem(w), w, i));
        end
        first_g = 1'b0;
        if (stop_after == 0) begin
            @(negedge clock);
            if (halted) do_reset();
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [31:0] w;
        case ($urandom_range(0, 12))
            0:  w = {11'b10001011000, r[20:0]};
            1:  w = {11'b11001011000, r[20:0]};
            2:  w = {11'b10001010000, r[20:0]};
            3:  w = {11'b10101010000, r[20:0]};
            4:  w = {11'b10101011000, r[20:0]};
            5:  w = {11'b11101011000, r[20:0]};
            6:  w = {10'b1001000100, r[21:0]};
            7:  w = {10'b1101000100, r[21:0]};
            8:  w = {11'b11111000010, r[20:0]};
            9:  w = {11'b11111000000, r[20:0]};
            10: w = {8'b10110100, r[23:0]};
            11: w = {6'b000101, r[25:0]};
            default: w = r;
        endcase
        if ($urandom_range(0, 7) == 0) w[4:0] = 5'd31;
        return w;
    endfunction

    initial begin
        do_reset();
        run_instr({10'b1001000100, 12'd5, 5'd31, 5'd1}, -1, 0);            // ADDI X1,X31,#5
        run_instr({11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2}, -1, 0);    // LDUR X2,[X1,#-8]
        run_instr({8'b10110100, 19'd4, 5'd3}, 1, 0);                       // CBZ X3,#4 taken
        run_instr({8'b10110100, 19'd4, 5'd3}, 0, 0);                       // CBZ X3,#4 not taken
        run_instr({11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd31}, -1, 0);      // ADD X31,X1,X2
        run_instr({11'b11101011000, 5'd4, 6'd0, 5'd5, 5'd6}, -1, 0);       // SUBS X6,X5,X4
        run_instr(32'h0000_0000, -1, 0);
        mw_seen  = 1'b0;
        mw_watch = 1'b1;
        run_instr({11'b11111000000, 9'h010, 2'b00, 5'd7, 5'd8}, -1, 4);    // STUR, abort in MEM
        @(negedge clock);
        do_reset();
        check_value("stur_abort/memwrite", 64'(mw_seen), 64'd0);
        mw_watch = 1'b0;
        run_instr({11'b10001010000, 5'd9, 6'd0, 5'd10, 5'd11}, -1, 0);     // AND after abort
        for (int i = 0; i < 150; i++) run_instr(rand_instr(), -1, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
